// File: rtl/uart_pkg.sv
// uart_pkg: transmitter FSM states and parity-mode encodings shared by the UART TX slice.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic parity_on(input logic [1:0] mode);
        return mode == PAR_EVEN || mode == PAR_ODD;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; pointers carry one extra wrap bit so level is their difference.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_q[AW-1:0]];
    assign level = wr_q - rd_q;
    assign full  = level == (AW+1)'(DEPTH);
    assign empty = wr_q == rd_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a TX FIFO, with level interrupt and sticky overflow.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    input  logic [DIV_W-1:0]            dvsr,
    input  logic [1:0]                  parity_mode,
    input  logic                        stop_2,
    input  logic                        tx_enable,
    input  logic [$clog2(FIFO_DEPTH):0] thresh,
    input  logic                        ovf_clr,
    output logic                        serial_out,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        busy,
    output logic                        overflow,
    output logic                        tx_intr
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = 3;

    tx_state_e         state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  dvsr_q, dvsr_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [1:0]        pmode_q, pmode_d;
    logic              par_q, par_d;
    logic              stop2_q, stop2_d;
    logic              stop_hi_q, stop_hi_d;
    logic              ovf_q, ovf_d;
    logic              intr_q, intr_d;
    logic [DATA_W-1:0] rdata;
    logic [LW-1:0]     lvl_d;
    logic              pop;
    logic              push_ok;
    logic              tick;
    logic              frame_end;
    logic              load;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (pop),
        .wdata (wr_data[DATA_W-1:0]),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign tick      = cnt_q == dvsr_q;
    assign frame_end = state_q == ST_STOP && tick && (!stop2_q || stop_hi_q);
    // a new frame may start from idle or straight out of the final stop-bit cycle
    assign load      = tx_enable && !empty && (state_q == ST_IDLE || frame_end);
    assign pop       = load;
    assign push_ok   = wr_en && (!full || pop);
    assign lvl_d     = level + LW'(push_ok) - LW'(pop);
    assign ovf_d     = (wr_en && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    assign intr_d    = lvl_d <= thresh;

    always_comb begin
        state_d   = state_q;
        cnt_d     = state_q == ST_IDLE ? cnt_q : tick ? '0 : cnt_q + 1'b1;
        dvsr_d    = dvsr_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        pmode_d   = pmode_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        stop_hi_d = stop_hi_q;
        case (state_q)
            ST_START:  if (tick) begin
                state_d = ST_DATA;
                bit_d   = '0;
            end
            ST_DATA:   if (tick) begin
                sh_d  = sh_q >> 1;
                bit_d = bit_q + 1'b1;
                if (bit_q == BW'(DATA_W - 1)) state_d = parity_on(pmode_q) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP:   if (tick) begin
                stop_hi_d = 1'b1;
                if (frame_end) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d   = ST_START;
            cnt_d     = '0;
            dvsr_d    = dvsr;
            pmode_d   = parity_mode;
            stop2_d   = stop_2;
            stop_hi_d = 1'b0;
            sh_d      = rdata;
            par_d     = ^rdata ^ (parity_mode == PAR_ODD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dvsr_q    <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            pmode_q   <= PAR_NONE;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            stop_hi_q <= 1'b0;
            ovf_q     <= 1'b0;
            intr_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvsr_q    <= dvsr_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            pmode_q   <= pmode_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            stop_hi_q <= stop_hi_d;
            ovf_q     <= ovf_d;
            intr_q    <= intr_d;
        end
    end

    assign serial_out = state_q == ST_START  ? 1'b0 :
                        state_q == ST_DATA   ? sh_q[0] :
                        state_q == ST_PARITY ? par_q : 1'b1;
    assign busy       = state_q != ST_IDLE;
    assign overflow   = ovf_q;
    assign tx_intr    = intr_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, parity, FIFO status, interrupt level and async reset.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_en7 = 1'b0;
    logic [7:0]  wr_data = '0;
    logic [15:0] dvsr = 16'd3;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop_2 = 1'b0;
    logic        tx_enable = 1'b0;
    logic [4:0]  thresh = 5'd2;
    logic        ovf_clr = 1'b0;

    logic       so8, full8, empty8, busy8, ovf8, intr8;
    logic [4:0] level8;
    logic       so7, full7, empty7, busy7, ovf7, intr7;
    logic [4:0] level7;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo dut (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_data (wr_data), .dvsr (dvsr),
        .parity_mode (parity_mode), .stop_2 (stop_2), .tx_enable (tx_enable), .thresh (thresh),
        .ovf_clr (ovf_clr), .serial_out (so8), .full (full8), .empty (empty8), .level (level8),
        .busy (busy8), .overflow (ovf8), .tx_intr (intr8)
    );

    uart_tx_fifo #(.DATA_W(7)) dut7 (
        .clk (clk), .rst (rst), .wr_en (wr_en7), .wr_data (wr_data), .dvsr (dvsr),
        .parity_mode (parity_mode), .stop_2 (stop_2), .tx_enable (tx_enable), .thresh (thresh),
        .ovf_clr (ovf_clr), .serial_out (so7), .full (full7), .empty (empty7), .level (level7),
        .busy (busy7), .overflow (ovf7), .tx_intr (intr7)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // bit i of bits (sent first at i=0) held for per samples
    function automatic logic [63:0] expand(input logic [31:0] bits, input int nbits, input int per);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < nbits; i++)
            for (int j = 0; j < per; j++)
                w[i*per+j] = bits[i];
        return w;
    endfunction

    task automatic capture(input bit sel7, input int n, output logic [63:0] line, output int nbusy);
        line  = '0;
        nbusy = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            line[i] = sel7 ? so7 : so8;
            nbusy  += int'(sel7 ? busy7 : busy8);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] line;
        int          nb;
        #2 rst = 1'b0;
        #1;
        check("rst_serial", so8, 1'b1);
        check("rst_busy", busy8, 1'b0);
        check("rst_empty", empty8, 1'b1);
        check("rst_full", full8, 1'b0);
        check("rst_level", level8, 5'd0);
        check("rst_ovf", ovf8, 1'b0);
        check("rst_intr", intr8, 1'b1);
        tick();
        rst = 1'b1;
        tick();

        tx_enable = 1'b1;
        push(8'hA5);
        check("push_level", level8, 5'd1);
        check("push_no_start", so8, 1'b1);
        capture(0, 44, line, nb);
        check("frame_8n1", line, expand({1'b1, 1'b1, 8'hA5, 1'b0}, 11, 4));
        check("busy_8n1", nb, 40);

        parity_mode = 2'b01;
        push(8'hA5);
        capture(0, 48, line, nb);
        check("frame_even", line, expand({1'b1, 1'b1, 1'b0, 8'hA5, 1'b0}, 12, 4));
        check("busy_even", nb, 44);

        parity_mode = 2'b10;
        push(8'hA5);
        capture(0, 48, line, nb);
        check("frame_odd", line, expand({1'b1, 1'b1, 1'b1, 8'hA5, 1'b0}, 12, 4));
        check("busy_odd", nb, 44);

        parity_mode = 2'b11;
        stop_2      = 1'b1;
        push(8'h3C);
        capture(0, 48, line, nb);
        check("frame_8n2", line, expand({1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, 12, 4));
        check("busy_8n2", nb, 44);
        parity_mode = 2'b00;
        stop_2      = 1'b0;

        wr_en7  = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en7  = 1'b0;
        capture(1, 40, line, nb);
        check("frame_7n1", line, expand({1'b1, 1'b1, 7'h25, 1'b0}, 10, 4));
        check("busy_7n1", nb, 36);

        tx_enable = 1'b0;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        check("full_flag", full8, 1'b1);
        check("full_level", level8, 5'd16);
        check("full_empty", empty8, 1'b0);
        check("full_no_ovf", ovf8, 1'b0);
        check("full_intr", intr8, 1'b0);
        push(8'hEE);
        check("ovf_level", level8, 5'd16);
        check("ovf_set", ovf8, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf8, 1'b0);
        wr_en   = 1'b1;
        ovf_clr = 1'b1;
        tick();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        check("ovf_set_wins", ovf8, 1'b1);

        dvsr      = 16'd0;
        tx_enable = 1'b1;
        tick();
        tx_enable = 1'b0;
        check("div0_start", so8, 1'b0);
        check("div0_pop_level", level8, 5'd15);
        capture(0, 12, line, nb);
        check("div0_frame_head", line, 64'hF10);
        check("div0_busy", nb, 9);
        check("no_restart_level", level8, 5'd15);

        dvsr      = 16'd3;
        tx_enable = 1'b1;
        repeat (10) tick();
        check("pre_rst_line", so8, 1'b0);
        check("pre_rst_busy", busy8, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("arst_serial", so8, 1'b1);
        check("arst_busy", busy8, 1'b0);
        check("arst_level", level8, 5'd0);
        check("arst_empty", empty8, 1'b1);
        check("arst_intr", intr8, 1'b1);
        tick();
        rst = 1'b1;
        capture(0, 16, line, nb);
        check("post_rst_idle", line, 64'hFFFF);
        check("post_rst_busy", nb, 0);

        tx_enable = 1'b0;
        dvsr      = 16'd1;
        push(8'h11);
        push(8'h22);
        check("intr_at_2", intr8, 1'b1);
        push(8'h33);
        check("thr_level3", level8, 5'd3);
        check("thr_intr_low", intr8, 1'b0);
        tx_enable = 1'b1;
        tick();
        check("thr_pop_level", level8, 5'd2);
        check("thr_intr_rise", intr8, 1'b1);
        check("b2b_start", so8, 1'b0);
        capture(0, 59, line, nb);
        check("b2b_line", line, expand({1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}, 30, 2) >> 1);
        check("b2b_busy", nb, 59);
        tick();
        check("b2b_done_busy", busy8, 1'b0);
        check("b2b_done_line", so8, 1'b1);
        check("b2b_done_empty", empty8, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
